// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath: the serializer FSM
// encoding and the default word width. The detector states will move here.
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage : serial_pkg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage. Words arrive on a valid/ready handshake and
// leave one bit per clock on sout. A one-word holding register lets the
// next word load in the cycle right after the current last bit.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam int              OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bitcnt, bitcnt_nxt;
    logic [WIDTH-1:0] hold_reg, hold_reg_nxt;
    logic             hold_full, hold_full_nxt;

    logic             free;
    logic             xfer;

    // Ready depends only on the holding register, never on din_valid.
    assign din_ready = !hold_full;
    assign xfer      = din_valid && din_ready;
    assign free      = (state == ST_IDLE) || ((state == ST_SHIFT) && (bitcnt == '0));

    // Next-state: drain hold first, else bypass a fresh word, else shift.
    always_comb begin
        // NOTE: every target gets a default before any branch, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt     = state;
        shreg_nxt     = shreg;
        bitcnt_nxt    = bitcnt;
        hold_reg_nxt  = hold_reg;
        hold_full_nxt = hold_full;

        case (state)
            ST_IDLE, ST_SHIFT: begin
                if (free) begin
                    if (hold_full) begin
                        shreg_nxt     = hold_reg;
                        hold_full_nxt = 1'b0;
                        state_nxt     = ST_SHIFT;
                        bitcnt_nxt    = CNT_LAST;
                    end else if (xfer) begin
                        shreg_nxt     = din;
                        state_nxt     = ST_SHIFT;
                        bitcnt_nxt    = CNT_LAST;
                    end else begin
                        state_nxt     = ST_IDLE;
                    end
                end else begin
                    shreg_nxt  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    bitcnt_nxt = bitcnt - 1'b1;
                    if (xfer) begin
                        hold_reg_nxt  = din;
                        hold_full_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous clear of the whole datapath.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (RST) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bitcnt    <= bitcnt_nxt;
            hold_reg  <= hold_reg_nxt;
            hold_full <= hold_full_nxt;
        end
    end

    // Serial outputs decode straight from the registers.
    always_comb begin
        sout_valid = (state == ST_SHIFT);
        sout       = sout_valid ? shreg[OUT_IDX] : 1'b0;
        sout_last  = sout_valid && (bitcnt == '0);
        busy       = (state == ST_SHIFT) || hold_full;
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// share clock and reset. Expected bit streams are computed from the words.
module tb_piso_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;

    logic [7:0] din_a = '0, din_b = '0;
    logic       din_valid_a = 1'b0, din_valid_b = 1'b0;
    logic       din_ready_a, sout_a, sout_valid_a, sout_last_a, busy_a;
    logic       din_ready_b, sout_b, sout_valid_b, sout_last_b, busy_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] words [0:255];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .CLK        (CLK),
        .RST        (RST),
        .din        (din_a),
        .din_valid  (din_valid_a),
        .din_ready  (din_ready_a),
        .sout       (sout_a),
        .sout_valid (sout_valid_a),
        .sout_last  (sout_last_a),
        .busy       (busy_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .CLK        (CLK),
        .RST        (RST),
        .din        (din_b),
        .din_valid  (din_valid_b),
        .din_ready  (din_ready_b),
        .sout       (sout_b),
        .sout_valid (sout_valid_b),
        .sout_last  (sout_last_b),
        .busy       (busy_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Streams words[0..n-1] into the MSB-first instance with random valid
    // throttling and checks every emitted bit against a queue of expected bits.
    task automatic run_stream(input string tag, input int n, input int duty,
                              output int gaps, output logic rdy_after_2nd);
        bit   exp_bit [$];
        bit   exp_last[$];
        int   sent    = 0;
        int   cyc     = 0;
        bit   started = 0;
        logic xfer;
        gaps          = 0;
        rdy_after_2nd = 1'bx;
        while ((sent < n || exp_bit.size() > 0) && cyc < 20000) begin
            if (sent < n) begin
                din_valid_a = ($urandom_range(99) < duty);
                din_a       = words[sent];
            end else begin
                din_valid_a = 1'b0;
            end
            xfer = din_valid_a && din_ready_a;
            if (xfer) begin
                for (int i = 7; i >= 0; i--) begin
                    exp_bit.push_back(words[sent][i]);
                    exp_last.push_back(i == 0);
                end
                sent++;
            end
            tick();
            cyc++;
            if (xfer && sent == 2) rdy_after_2nd = din_ready_a;
            if (sout_valid_a) begin
                started = 1;
                if (exp_bit.size() == 0) begin
                    check({tag, " unexpected bit"}, 32'd1, 32'd0);
                end else begin
                    if (sout_a !== exp_bit[0])
                        check({tag, " bit"}, {31'd0, sout_a}, {31'd0, exp_bit[0]});
                    if (sout_last_a !== exp_last[0])
                        check({tag, " last"}, {31'd0, sout_last_a}, {31'd0, exp_last[0]});
                    void'(exp_bit.pop_front());
                    void'(exp_last.pop_front());
                end
            end else if (started && exp_bit.size() > 0) begin
                gaps++;
            end
        end
        din_valid_a = 1'b0;
        check({tag, " timeout"}, {31'd0, (cyc >= 20000)}, 32'd0);
        check({tag, " words sent"}, sent, n);
        check({tag, " bits left"}, exp_bit.size(), 0);
    endtask

    initial begin
        int         gaps;
        logic       rdy2;
        logic [3:0] win;
        logic [7:0] v;

        // ---- 1: reset then idle ----
        #2;
        check("reset sout_valid", sout_valid_a, 0);
        check("reset din_ready", din_ready_a, 1);
        tick(); tick();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle sout", sout_a, 0);
            check("idle sout_valid", sout_valid_a, 0);
            check("idle busy", busy_a, 0);
            check("idle din_ready", din_ready_a, 1);
        end

        // ---- 2: single word 8'hB6 MSB first, with 1011 window ----
        v = 8'hB6;
        din_a = v; din_valid_a = 1'b1;
        tick();
        din_valid_a = 1'b0;
        win = '0;
        for (int i = 0; i < 8; i++) begin
            check("b6 sout_valid", sout_valid_a, 1);
            check("b6 sout", sout_a, v[7-i]);
            check("b6 sout_last", sout_last_a, (i == 7));
            check("b6 busy", busy_a, 1);
            win = {win[2:0], sout_a};
            check("b6 det", (win == 4'b1011), (i == 3 || i == 6));
            tick();
        end
        check("b6 done valid", sout_valid_a, 0);
        check("b6 done busy", busy_a, 0);

        // ---- 3: back-to-back stream B6, 0B, FF ----
        words[0] = 8'hB6; words[1] = 8'h0B; words[2] = 8'hFF;
        run_stream("stream3", 3, 100, gaps, rdy2);
        check("stream3 gaps", gaps, 0);
        check("stream3 ready after 2nd", rdy2, 0);
        tick();
        check("stream3 idle after", sout_valid_a, 0);

        // ---- 4: LSB first 8'h0D ----
        v = 8'h0D;
        din_b = v; din_valid_b = 1'b1;
        tick();
        din_valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb sout_valid", sout_valid_b, 1);
            check("lsb sout", sout_b, v[i]);
            check("lsb sout_last", sout_last_b, (i == 7));
            tick();
        end
        check("lsb done valid", sout_valid_b, 0);

        // ---- 5: asynchronous reset with a word held ----
        din_a = 8'hC3; din_valid_a = 1'b1;
        tick();                       // 1st bit shown
        din_a = 8'h5A;
        tick();                       // 2nd bit shown, 5A held
        din_valid_a = 1'b0;
        check("rst5 hold full", din_ready_a, 0);
        tick();                       // 3rd bit shown
        check("rst5 3rd bit", sout_a, 0);
        check("rst5 busy before", busy_a, 1);
        #2 RST = 1'b1;
        #1;
        check("rst5 async sout_valid", sout_valid_a, 0);
        check("rst5 async sout", sout_a, 0);
        check("rst5 async sout_last", sout_last_a, 0);
        check("rst5 async busy", busy_a, 0);
        check("rst5 async din_ready", din_ready_a, 1);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rst5 no residue", sout_valid_a, 0);
        end
        v = 8'hA5;
        din_a = v; din_valid_a = 1'b1;
        tick();
        din_valid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("rst5 clean sout", {sout_valid_a, sout_a}, {1'b1, v[7-i]});
            tick();
        end
        check("rst5 clean end", sout_valid_a, 0);

        // ---- 6: 200 random words with 30% valid duty ----
        for (int i = 0; i < 200; i++) words[i] = 8'($urandom);
        run_stream("rand6", 200, 30, gaps, rdy2);
        check("rand6 gaps", gaps, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_piso_serializer

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that feeds the bit-serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on sout, with a qualifying sout_valid.
- A one-word holding register allows gapless back-to-back streaming.
- sout connects directly to the detector's serial input.

Parameters:
- WIDTH, 8: word width in bits; legal range >= 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  parallel word to serialise.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can take a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a payload bit this cycle.
- sout_last  output  1  sout carries the final bit of a word.
- busy  output  1  shifting in progress or a word is pending.

Behaviour:
- Reset, asynchronous on RST high:
  - state=IDLE; shreg, bitcnt, hold_reg cleared; hold_full=0.
  - Outputs: sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1 (combinational from hold_full=0).
  - Reset mid-word discards the in-flight word and any held word, with no further bits emitted.
- Registers:
  - shreg[WIDTH-1:0].
  - bitcnt, $clog2(WIDTH) bits, counting bits remaining minus one.
  - hold_reg[WIDTH-1:0] and hold_full.
- Handshake:
  - din_ready = !hold_full, with no combinational path from din_valid.
  - Transfer occurs when din_valid && din_ready at a rising edge.
  - din_valid may be deasserted freely; no word is consumed without ready.
- "free" (combinational) = (state==IDLE) || (state==SHIFT && bitcnt==0).
- Load priority at each edge when free:
  1. hold_full=1: shreg<=hold_reg, hold_full<=0. A simultaneous transfer is impossible because ready=0.
  2. Otherwise, a transfer is occurring: shreg<=din directly (bypass); the hold register stays empty.
  3. Otherwise: state<=IDLE.
  - Any load sets state<=SHIFT and bitcnt<=WIDTH-1.
- A transfer when not free writes hold_reg<=din and hold_full<=1.
- In SHIFT and not loading:
  - shreg shifts toward the output end (left if MSB_FIRST, else right), filling with 0.
  - bitcnt<=bitcnt-1.
- Outputs (combinational from registers):
  - sout_valid = (state==SHIFT).
  - sout = sout_valid ? shreg[MSB_FIRST ? WIDTH-1 : 0] : 0.
  - sout_last = sout_valid && bitcnt==0.
  - busy = (state==SHIFT) || hold_full.
- Latency: a word transferred at edge k in IDLE shows its first bit in the cycle after edge k, and its last bit WIDTH-1 cycles later.
- Streaming:
  - If the next word is transferred no later than the cycle in which the current word's sout_last is high, its first bit follows the current last bit with zero gap.
  - Sustained throughput is 1 word per WIDTH cycles.
- Ordering: words leave strictly in transfer order; hold_reg is always drained before the bypass path is used.
- The FSM has two states, IDLE and SHIFT; an illegal encoding recovers to IDLE.

Decomposition:
- Shared package serial_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default width constant SER_WIDTH_DEFAULT=8.
  - The detector states are to move into this package later.
- No sub-module; holding register, shifter and FSM stay in one module.
- The test wrapper instantiates piso_serializer driving the existing 1011 detector, with sout feeding the detector's serial input.

Test Plan:
1. Reset, then idle with din_valid=0 for 10 cycles -> sout=0, sout_valid=0, busy=0, din_ready=1 throughout.
2. WIDTH=8, MSB_FIRST=1, single transfer din=8'hB6 -> over the next 8 cycles sout=1,0,1,1,0,1,1,0 with sout_valid=1 and sout_last only on the 8th. The chained detector det pulses on bit 4 and bit 7 (overlap case). Then sout_valid=0.
3. Back-to-back stream 8'hB6, 8'h0B, 8'hFF with din_valid held high -> 24 consecutive sout_valid cycles with no gaps. din_ready drops after the 2nd transfer and rises again when hold drains. Bit order matches transfer order.
4. MSB_FIRST=0, din=8'h0D -> sout=1,0,1,1,0,0,0,0.
5. Assert RST asynchronously (mid-cycle) after the 3rd bit while hold_full=1 -> outputs go to reset values immediately, without waiting for a clock edge. After release, no residual bits appear and the next word starts clean.
6. Random din_valid throttling (30% duty) over 200 words, checked against a scoreboard queue -> exact bit sequence preserved and no word lost or duplicated.
